// File: rtl/audio_sample_arbiter_pkg.sv
// Shared audio definitions: sample width, default tone constants and effect states.
// The default amplitude and half-period constants are also used by the volume/menu block.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned CNT_W    = 16;

  localparam logic [SAMPLE_W-1:0] DEF_MUSIC_AMP = 24'h100000;
  localparam logic [SAMPLE_W-1:0] DEF_SFX_AMP   = 24'h200000;

  localparam int unsigned DEF_SCORE_HALF    = 24;
  localparam int unsigned DEF_SCORE_LEN     = 4800;
  localparam int unsigned DEF_CRASH_HALF1   = 60;
  localparam int unsigned DEF_CRASH_HALF2   = 90;
  localparam int unsigned DEF_CRASH_HALF3   = 120;
  localparam int unsigned DEF_CRASH_SEG_LEN = 7200;

  typedef enum logic [2:0] {
    SFX_IDLE,
    SFX_SCORE,
    SFX_CRASH1,
    SFX_CRASH2,
    SFX_CRASH3
  } sfx_state_t;

  // State reached when the current effect segment runs out.
  function automatic sfx_state_t sfx_after(input sfx_state_t st);
    sfx_state_t nxt;
    case (st)
      SFX_CRASH1: nxt = SFX_CRASH2;
      SFX_CRASH2: nxt = SFX_CRASH3;
      default:    nxt = SFX_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/audio_sample_arbiter_sq_tone_gen.sv
// Square-wave phase generator advanced by sample ticks.
// The phase flips every `half` ticks; clr restarts the tone at phase 0.
module sq_tone_gen
  import audio_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  input  logic [CNT_W-1:0] half,
  output logic             phase
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      if (cnt == half - CNT_W'(1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/audio_sample_arbiter.sv
// Shares the codec DAC write port between background music and sound-effect cues.
// One mixed, saturated sample is issued per write_ready/write handshake.
module audio_sample_arbiter
  import audio_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] MUSIC_AMP     = DEF_MUSIC_AMP,
  parameter logic [SAMPLE_W-1:0] SFX_AMP       = DEF_SFX_AMP,
  parameter int unsigned         SCORE_HALF    = DEF_SCORE_HALF,
  parameter int unsigned         SCORE_LEN     = DEF_SCORE_LEN,
  parameter int unsigned         CRASH_HALF1   = DEF_CRASH_HALF1,
  parameter int unsigned         CRASH_HALF2   = DEF_CRASH_HALF2,
  parameter int unsigned         CRASH_HALF3   = DEF_CRASH_HALF3,
  parameter int unsigned         CRASH_SEG_LEN = DEF_CRASH_SEG_LEN
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                music_bit,
  input  logic                music_en,
  input  logic                game_over,
  input  logic                crash_evt,
  input  logic                score_evt,
  input  logic                write_ready,
  output logic                write,
  output logic                read,
  output logic [SAMPLE_W-1:0] writedata_left,
  output logic [SAMPLE_W-1:0] writedata_right,
  output logic                sfx_busy
);

  localparam logic signed [SAMPLE_W:0] M_AMP   = $signed({1'b0, MUSIC_AMP});
  localparam logic signed [SAMPLE_W:0] S_AMP   = $signed({1'b0, SFX_AMP});
  localparam logic signed [SAMPLE_W:0] SAT_MAX = $signed({2'b00, {(SAMPLE_W-1){1'b1}}});
  localparam logic signed [SAMPLE_W:0] SAT_MIN = $signed({2'b11, {(SAMPLE_W-1){1'b0}}});

  logic [1:0]        music_sync;
  logic              crash_pend, score_pend;
  sfx_state_t        state, state_d;
  logic              enter;
  logic [CNT_W-1:0]  dur, seg_len, half;
  logic              phase;
  logic signed [SAMPLE_W:0] m_raw, m_term, s_term, sum;
  logic [SAMPLE_W-1:0] sample;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      music_sync <= '0;
      crash_pend <= 1'b0;
      score_pend <= 1'b0;
    end else begin
      music_sync <= {music_sync[0], music_bit};
      // Events are held for one cycle and the FSM consumes them regardless of ticks.
      crash_pend <= crash_evt;
      score_pend <= score_evt;
    end
  end

  always_comb begin
    case (state)
      SFX_SCORE:  begin half = CNT_W'(SCORE_HALF);  seg_len = CNT_W'(SCORE_LEN);     end
      SFX_CRASH1: begin half = CNT_W'(CRASH_HALF1); seg_len = CNT_W'(CRASH_SEG_LEN); end
      SFX_CRASH2: begin half = CNT_W'(CRASH_HALF2); seg_len = CNT_W'(CRASH_SEG_LEN); end
      SFX_CRASH3: begin half = CNT_W'(CRASH_HALF3); seg_len = CNT_W'(CRASH_SEG_LEN); end
      default:    begin half = CNT_W'(SCORE_HALF);  seg_len = CNT_W'(SCORE_LEN);     end
    endcase
  end

  // enter must be combinational so the tone generator clears on the same edge as the state change.
  always_comb begin
    state_d = state;
    enter   = 1'b0;
    if (crash_pend) begin
      state_d = SFX_CRASH1;
      enter   = 1'b1;
    end else if (score_pend && state == SFX_IDLE) begin
      state_d = SFX_SCORE;
      enter   = 1'b1;
    end else if (write && state != SFX_IDLE && dur == seg_len - CNT_W'(1)) begin
      state_d = sfx_after(state);
      enter   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= SFX_IDLE;
      sfx_busy <= 1'b0;
      dur      <= '0;
    end else begin
      state    <= state_d;
      sfx_busy <= (state_d != SFX_IDLE);
      if (enter)
        dur <= '0;
      else if (write && state != SFX_IDLE)
        dur <= dur + CNT_W'(1);
    end
  end

  sq_tone_gen u_tone (
    .clk   (clk),
    .rst_n (resetn),
    .tick  (write),
    .clr   (enter),
    .half  (half),
    .phase (phase)
  );

  always_comb begin
    m_raw = '0;
    if (music_en && !game_over)
      m_raw = music_sync[1] ? M_AMP : -M_AMP;
    m_term = (state != SFX_IDLE) ? (m_raw >>> 2) : m_raw;
    s_term = '0;
    if (state != SFX_IDLE)
      s_term = phase ? -S_AMP : S_AMP;
    sum = m_term + s_term;
    if (sum > SAT_MAX)
      sample = SAT_MAX[SAMPLE_W-1:0];
    else if (sum < SAT_MIN)
      sample = SAT_MIN[SAMPLE_W-1:0];
    else
      sample = sum[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write          <= 1'b0;
      writedata_left <= '0;
    end else begin
      write <= write_ready && !write;
      if (write_ready && !write)
        writedata_left <= sample;
    end
  end

  assign writedata_right = writedata_left;
  assign read            = 1'b0;

endmodule

// File: tb/tb_audio_sample_arbiter.sv
// Bench for audio_sample_arbiter: directed scenarios plus random traffic against a
// tick/phase arithmetic model, with a default and a saturating-amplitude instance.
module tb_audio_sample_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic music_bit = 1'b1, music_en = 1'b1, game_over = 1'b0;
  logic crash_evt = 1'b0, score_evt = 1'b0, write_ready = 1'b0;
  logic write, read, sfx_busy;
  logic [23:0] wd_left, wd_right;
  logic s_write, s_read, s_busy;
  logic [23:0] s_left, s_right;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  audio_sample_arbiter dut (
    .clk(clk), .resetn(resetn), .music_bit(music_bit), .music_en(music_en),
    .game_over(game_over), .crash_evt(crash_evt), .score_evt(score_evt),
    .write_ready(write_ready), .write(write), .read(read),
    .writedata_left(wd_left), .writedata_right(wd_right), .sfx_busy(sfx_busy)
  );

  audio_sample_arbiter #(.MUSIC_AMP(24'h7FFFFF), .SFX_AMP(24'h7FFFFF)) dut_sat (
    .clk(clk), .resetn(resetn), .music_bit(music_bit), .music_en(music_en),
    .game_over(game_over), .crash_evt(crash_evt), .score_evt(score_evt),
    .write_ready(write_ready), .write(s_write), .read(s_read),
    .writedata_left(s_left), .writedata_right(s_right), .sfx_busy(s_busy)
  );

  // Behavioural model: state index 0=idle,1=score,2..4=crash tones; phase = (ticks/half)%2.
  int          m_state = 0;
  int          m_ticks = 0;
  bit          m_write = 1'b0;
  bit          p_crash = 1'b0, p_score = 1'b0;
  bit [1:0]    msync = 2'b00;
  logic [23:0] wd_a = '0, wd_b = '0;

  function automatic int half_of(input int st);
    case (st)
      2: return 60;
      3: return 90;
      4: return 120;
      default: return 24;
    endcase
  endfunction

  function automatic int len_of(input int st);
    return (st == 1) ? 4800 : 7200;
  endfunction

  function automatic logic [23:0] mix(input int mamp, input int samp);
    int m, s, sum;
    m = 0;
    if (music_en && !game_over) m = msync[1] ? mamp : -mamp;
    if (m_state != 0) m = (m >= 0) ? m / 4 : -((-m + 3) / 4);
    s = 0;
    if (m_state != 0) s = (((m_ticks / half_of(m_state)) % 2) == 0) ? samp : -samp;
    sum = m + s;
    if (sum > 8388607) sum = 8388607;
    if (sum < -8388608) sum = -8388608;
    return sum[23:0];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_state = 0; m_ticks = 0; m_write = 1'b0;
      p_crash = 1'b0; p_score = 1'b0; msync = 2'b00;
      wd_a = '0; wd_b = '0;
    end else begin
      bit was_tick;
      was_tick = m_write;
      if (write_ready && !m_write) begin
        wd_a = mix(24'h100000, 24'h200000);
        wd_b = mix(24'h7FFFFF, 24'h7FFFFF);
      end
      if (p_crash) begin
        m_state = 2; m_ticks = 0;
      end else if (p_score && m_state == 0) begin
        m_state = 1; m_ticks = 0;
      end else if (was_tick && m_state != 0) begin
        m_ticks++;
        if (m_ticks == len_of(m_state)) begin
          m_state = (m_state == 1 || m_state == 4) ? 0 : m_state + 1;
          m_ticks = 0;
        end
      end
      m_write = write_ready && !m_write;
      p_crash = crash_evt;
      p_score = score_evt;
      msync   = {msync[0], music_bit};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && run) begin
      logic [98:0] act, exp;
      act = {write, read, sfx_busy, wd_left, wd_right, s_left, s_right};
      exp = {m_write, 1'b0, (m_state != 0), wd_a, wd_a, wd_b, wd_b};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_model: got %h expected %h at %0t", act, exp, $time);
      end
      if ({s_write, s_read, s_busy} !== {m_write, 1'b0, (m_state != 0)}) begin
        errors++;
        $display("FAIL sat_ctrl: got %b expected %b at %0t", {s_write, s_read, s_busy},
                 {m_write, 1'b0, (m_state != 0)}, $time);
      end
    end
  end

  initial begin
    int j, k, cyc, nwr;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_write", {31'd0, write}, 32'd0);
    check("reset_read", {31'd0, read}, 32'd0);
    check("reset_data", {8'd0, wd_left}, 32'd0);
    check("reset_busy", {31'd0, sfx_busy}, 32'd0);

    // Release with codec always ready: strobe every other cycle.
    resetn = 1'b1; write_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("write_toggle", {31'd0, write}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("third_strobe", {31'd0, write}, 32'd1);
    check("music_only", {8'd0, wd_left}, 32'h100000);
    check("music_only_sat", {8'd0, s_left}, 32'h7FFFFF);

    // Score event while the codec is not ready: stays pending, no writes, no advance.
    write_ready = 1'b0;
    @(negedge clk); score_evt = 1'b1;
    @(negedge clk); score_evt = 1'b0;
    nwr = 0;
    repeat (10000) begin
      @(negedge clk);
      if (write) nwr++;
    end
    check("no_write_unready", nwr, 0);
    check("score_pending_busy", {31'd0, sfx_busy}, 32'd1);
    write_ready = 1'b1;
    j = 0; cyc = 0;
    while (sfx_busy && cyc < 12000) begin
      if (write) begin
        if (j == 10) begin
          check("score_pos", {8'd0, wd_left}, 32'h240000);
          check("score_pos_sat", {8'd0, s_left}, 32'h7FFFFF);
        end
        if (j == 30) check("score_neg", {8'd0, wd_left}, 32'hE40000);
        j++;
      end
      @(negedge clk); cyc++;
    end
    check("score_ticks", j, 4800);

    // Crash preempts score 1000 ticks in; game_over mutes music from CRASH2.
    score_evt = 1'b1; @(negedge clk); score_evt = 1'b0;
    k = 0; cyc = 0;
    while (k < 1000 && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (write && sfx_busy) k++;
    end
    check("score_before_crash", k, 1000);
    music_bit = 1'b0;
    crash_evt = 1'b1; @(negedge clk); crash_evt = 1'b0; @(negedge clk);
    check("crash_preempt_busy", {31'd0, sfx_busy}, 32'd1);
    j = 0; cyc = 0;
    while (sfx_busy && cyc < 50000) begin
      if (write) begin
        if (j == 100) begin
          check("crash1_neg", {8'd0, wd_left}, 32'hDC0000);
          check("crash1_neg_sat", {8'd0, s_left}, 32'h800000);
        end
        if (j == 7250) game_over = 1'b1;
        if (j == 7300) begin
          check("crash2_muted", {8'd0, wd_left}, 32'hE00000);
          check("crash2_muted_sat", {8'd0, s_left}, 32'h800001);
        end
        j++;
      end
      @(negedge clk); cyc++;
    end
    check("crash_ticks", j, 21600);
    repeat (10) @(negedge clk);
    check("idle_game_over_silent", {8'd0, wd_left}, 32'd0);
    check("idle_busy", {31'd0, sfx_busy}, 32'd0);
    game_over = 1'b0; music_bit = 1'b1;

    // Simultaneous events, then random traffic.
    crash_evt = 1'b1; score_evt = 1'b1;
    @(negedge clk); crash_evt = 1'b0; score_evt = 1'b0;
    repeat (8000) begin
      @(negedge clk);
      write_ready = ($urandom_range(0, 9) < 7);
      crash_evt   = ($urandom_range(0, 999) == 0);
      score_evt   = ($urandom_range(0, 299) == 0);
      music_bit   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 499) == 0) music_en = ~music_en;
      if ($urandom_range(0, 499) == 0) game_over = ~game_over;
    end
    crash_evt = 1'b0; score_evt = 1'b0;
    music_en = 1'b1; game_over = 1'b0; write_ready = 1'b1;

    // Asynchronous reset in the middle of an effect.
    score_evt = 1'b1; @(negedge clk); score_evt = 1'b0;
    repeat (51) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_write", {31'd0, write}, 32'd0);
    check("async_data", {8'd0, wd_left}, 32'd0);
    check("async_data_r", {8'd0, wd_right}, 32'd0);
    check("async_busy", {31'd0, sfx_busy}, 32'd0);
    check("async_sat_data", {8'd0, s_left}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_sample_arbiter.md
Name: audio_sample_arbiter

Overview:
- Owns the audio codec DAC write port and shares it between two sources: background music and game sound effects.
- Background music is the 1-bit level from the existing music player. Sound effects are crash, score and game-over cues sequenced here.
- Produces one mixed 24-bit sample per codec write_ready/write handshake, so pacing follows the codec's 48 kHz FIFO drain.
- Sits at top level between music/check_crash/score logic and audio_codec, replacing the direct music-to-write connection.

Parameters:
- MUSIC_AMP, 24'h100000: music square-wave amplitude (signed magnitude).
- SFX_AMP, 24'h200000: effect square-wave amplitude.
- SCORE_HALF, 24: score beep half-period in samples (1 kHz).
- SCORE_LEN, 4800: score beep duration in samples (100 ms).
- CRASH_HALF1 / CRASH_HALF2 / CRASH_HALF3, 60 / 90 / 120: half-periods of the three descending crash tones.
- CRASH_SEG_LEN, 7200: samples per crash tone segment (150 ms).

Ports:
- clk  in  1  CLOCK_50 domain clock.
- resetn  in  1  reset, asynchronous, active-low.
- music_bit  in  1  music player output; asynchronous to clk.
- music_en  in  1  level; 0 mutes music.
- game_over  in  1  level from check_crash.
- crash_evt  in  1  one-clk pulse on life loss.
- score_evt  in  1  one-clk pulse on score increment.
- write_ready  in  1  codec DAC FIFO has space.
- write  out  1  one-cycle write strobe to codec.
- read  out  1  tied 0.
- writedata_left  out  24  signed sample.
- writedata_right  out  24  signed sample, always equal to left.
- sfx_busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset values: write=0, read=0, writedata_*=0, sfx_busy=0, state=IDLE, all counters 0, tone phase 0.
- music_bit passes through a 2-flop synchronizer before use. Two cycles of latency are acceptable.
- Handshake:
  - write is registered.
  - Set write=1 in cycle n+1 iff write_ready=1 in cycle n and write=0 in cycle n. Otherwise write=0.
  - Consequence: never two consecutive write cycles.
  - writedata_* update in the same cycle write rises and hold until the next strobe.
- Sample tick: a "tick" is each cycle with write=1. All tone and duration counters advance only on ticks, never on raw clk.
- FSM states: IDLE, SCORE, CRASH1, CRASH2, CRASH3.
  - IDLE -> CRASH1 on crash_evt. IDLE -> SCORE on score_evt. crash_evt wins if both arrive in the same cycle.
  - SCORE -> CRASH1 on crash_evt (preempt). SCORE -> IDLE after SCORE_LEN ticks.
  - CRASH1 -> CRASH2 -> CRASH3 -> IDLE, each after CRASH_SEG_LEN ticks.
  - During CRASHx, score_evt is dropped (not queued) and crash_evt restarts CRASH1.
  - Every state entry clears the duration counter, tone counter and phase.
- Tone generation: the tone counter counts ticks. When it reaches the state's half-period minus 1, phase toggles and the counter clears.
- Sample composition, all in signed 25-bit arithmetic:
  - Music term m:
    - 0 if game_over=1 or music_en=0.
    - Otherwise +MUSIC_AMP or -MUSIC_AMP per synchronized music_bit.
    - Arithmetic shift right by 2 (ducked) while sfx_busy.
  - Effect term s: 0 in IDLE, else +SFX_AMP or -SFX_AMP per phase.
  - Output: m+s saturated to 24-bit signed, range [-2^23, 2^23-1].
- game_over only mutes music. A crash sequence in progress runs to completion. Events are still accepted.
- Event pulses arriving between ticks are latched in one pending flag per event. The FSM consumes the flags at the next cycle; the event is not lost if no tick occurs.
- An asynchronous reset mid-sequence returns to IDLE immediately and write drops in the same cycle.
- A write_ready drop while write=1 is ignored: the strobe was already issued.

Decomposition:
- Shared package audio_pkg holds:
  - the state encoding constants;
  - SAMPLE_W=24;
  - the default amplitude and half-period constants, reused by a later volume/menu block.
- One natural sub-module: sq_tone_gen. It contains the tick-driven tone counter and phase, takes half-period and a clear input, and outputs phase. The FSM, mixer, saturation and handshake stay in the top of this block.

Test Plan:
- Reset hold, then write_ready=1 constant, music_en=1, music_bit=1 -> write toggles 1,0,1,0…; writedata=24'h100000 from the 3rd strobe after the synchronizer settles.
- score_evt pulse in IDLE -> sfx_busy=1 for exactly 4800 ticks.
  - Samples alternate 24'h040000+SFX_AMP and 24'h040000-SFX_AMP, every 24 ticks.
  - Exact values: 24'h240000 and 24'hE40000.
- crash_evt 1000 ticks into SCORE -> immediate CRASH1 with half-period 60, then 90, then 120, each lasting 7200 ticks. sfx_busy deasserts after exactly 21600 ticks.
- game_over=1 during CRASH2 -> music term 0, so samples are ±24'h200000; the sequence completes to IDLE; then all samples are 0.
- Parameter override SFX_AMP=24'h7FFFFF, MUSIC_AMP=24'h7FFFFF -> positive sum saturates to 24'h7FFFFF, negative sum to 24'h800000.
- write_ready held 0 for 10000 clk with score_evt pulsed -> no writes and no counter advance. The event stays pending, and SCORE lasts a full 4800 ticks once write_ready returns. resetn low mid-sequence -> all outputs 0 asynchronously.
